// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters (A = execute, B = branch/compare).
// Requests arrive over valid/ready and are granted round-robin. The granted request is
// held on the ALU inputs for ALU_LAT cycles, then result/zero are captured into a
// registered response that is held until the requester consumes it.
// Only one operation is in flight at a time.
//
// Ports:
//   clk_i, reset_i                 clock (rising edge), async active-high reset
//   a_valid_i/a_ready_o            port A request handshake (same-cycle)
//   a_opcode_i/a_rs_i/a_rt_i/a_imm_i  port A request payload
//   b_*                            port B, same set as port A
//   alu_opcode_o/rs_o/rt_o/imm_o   operands driven to the ALU
//   alu_result_i/alu_zero_i        ALU result and condition bit
//   rsp_valid_o/rsp_ready_i        response handshake
//   rsp_port_o                     0 = response for A, 1 = for B
//   rsp_result_o/rsp_cb_o/rsp_err_o  result, condition bit, undefined-opcode flag
module alu_arbiter #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned OP_W    = 4,
    parameter int unsigned IMM_W   = 5,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              a_valid_i,
    output logic              a_ready_o,
    input  logic [OP_W-1:0]   a_opcode_i,
    input  logic [DATA_W-1:0] a_rs_i,
    input  logic [DATA_W-1:0] a_rt_i,
    input  logic [IMM_W-1:0]  a_imm_i,
    input  logic              b_valid_i,
    output logic              b_ready_o,
    input  logic [OP_W-1:0]   b_opcode_i,
    input  logic [DATA_W-1:0] b_rs_i,
    input  logic [DATA_W-1:0] b_rt_i,
    input  logic [IMM_W-1:0]  b_imm_i,
    output logic [OP_W-1:0]   alu_opcode_o,
    output logic [DATA_W-1:0] alu_rs_o,
    output logic [DATA_W-1:0] alu_rt_o,
    output logic [IMM_W-1:0]  alu_imm_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_port_o,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_cb_o,
    output logic              rsp_err_o
);

    localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [OP_W-1:0] OP_SLT       = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SEQ       = OP_W'(7);
    localparam logic [OP_W-1:0] OP_FIRST_BAD = OP_W'(10);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e              state_q, state_d;
    logic                last_grant_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                port_q;
    logic [OP_W-1:0]     op_q;
    logic                err_q;
    logic [OP_W-1:0]     alu_opcode_q;
    logic [DATA_W-1:0]   alu_rs_q;
    logic [DATA_W-1:0]   alu_rt_q;
    logic [IMM_W-1:0]    alu_imm_q;
    logic [DATA_W-1:0]   rsp_result_q;
    logic                rsp_cb_q;
    logic                rsp_err_q;

    logic                grant;
    logic                hs;
    logic [OP_W-1:0]     sel_op;
    logic [DATA_W-1:0]   sel_rs;
    logic [DATA_W-1:0]   sel_rt;
    logic [IMM_W-1:0]    sel_imm;
    logic                sel_undef;
    logic                op_is_cmp;

    // Grant: a lone requester wins; on a tie the port that did not win last time wins.
    always_comb begin
        grant     = 1'b0;
        a_ready_o = 1'b0;
        b_ready_o = 1'b0;
        if (state_q == StIdle) begin
            grant     = (a_valid_i && b_valid_i) ? ~last_grant_q : b_valid_i;
            a_ready_o = a_valid_i & ~grant;
            b_ready_o = b_valid_i & grant;
        end
    end

    assign hs        = a_ready_o | b_ready_o;
    assign sel_op    = grant ? b_opcode_i : a_opcode_i;
    assign sel_rs    = grant ? b_rs_i     : a_rs_i;
    assign sel_rt    = grant ? b_rt_i     : a_rt_i;
    assign sel_imm   = grant ? b_imm_i    : a_imm_i;
    assign sel_undef = (sel_op >= OP_FIRST_BAD);
    assign op_is_cmp = (op_q == OP_SLT) || (op_q == OP_SEQ);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (hs) state_d = StIssue;
            StIssue: if (cnt_q == '0) state_d = StResp;
            StResp:  if (rsp_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            port_q       <= 1'b0;
            op_q         <= '0;
            err_q        <= 1'b0;
            alu_opcode_q <= '0;
            alu_rs_q     <= '0;
            alu_rt_q     <= '0;
            alu_imm_q    <= '0;
            rsp_result_q <= '0;
            rsp_cb_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                port_q       <= grant;
                last_grant_q <= grant;
                op_q         <= sel_op;
                err_q        <= sel_undef;
                // Never present an undefined opcode to the ALU.
                alu_opcode_q <= sel_undef ? '0 : sel_op;
                alu_rs_q     <= sel_rs;
                alu_rt_q     <= sel_rt;
                alu_imm_q    <= sel_imm;
                cnt_q        <= CNT_W'(ALU_LAT - 1);
            end
            if (state_q == StIssue) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    rsp_result_q <= (err_q || op_is_cmp) ? '0 : alu_result_i;
                    rsp_cb_q     <= (!err_q && op_is_cmp) ? alu_zero_i : 1'b0;
                    rsp_err_q    <= err_q;
                end
            end
        end
    end

    // ALU inputs are registered, so they hold their last values while idle.
    assign alu_opcode_o = alu_opcode_q;
    assign alu_rs_o     = alu_rs_q;
    assign alu_rt_o     = alu_rt_q;
    assign alu_imm_o    = alu_imm_q;
    assign rsp_valid_o  = (state_q == StResp);
    assign rsp_port_o   = port_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_cb_o     = rsp_cb_q;
    assign rsp_err_o    = rsp_err_q;

endmodule
